// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the direct-mapped write-back data cache controller:
//   - cache_state_e : controller FSM states
//   - DEF_*         : default address-field widths
//   - addr_tag / addr_index / addr_offset : split a byte address into fields
// The field helpers work on a 32-bit container so that any configured width
// up to 32 bits can use them; callers cast the result to the field width.
// -----------------------------------------------------------------------------
package cache_pkg;

    localparam int DEF_ADDR_W   = 10;
    localparam int DEF_INDEX_W  = 2;
    localparam int DEF_OFFSET_W = 4;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        COMPARE    = 2'd1,
        WRITE_BACK = 2'd2,
        ALLOCATE   = 2'd3
    } cache_state_e;

    function automatic logic [31:0] field_mask(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

    function automatic logic [31:0] addr_offset(input logic [31:0] addr,
                                                input int offset_w);
        return addr & field_mask(offset_w);
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] addr,
                                               input int index_w,
                                               input int offset_w);
        return (addr >> offset_w) & field_mask(index_w);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr,
                                             input int index_w,
                                             input int offset_w);
        return addr >> (index_w + offset_w);
    endfunction

endpackage

// File: rtl/cache_tag_store.sv
// -----------------------------------------------------------------------------
// cache_tag_store
// Tag, valid and dirty metadata for every cache line.
// Ports:
//   clock, reset_n             : clock, asynchronous active-low reset
//   rd_index -> rd_tag/valid/dirty : combinational lookup of one line
//   fill_en/fill_index/fill_tag : install a new tag, mark valid and clean
//   set_dirty_en/set_dirty_index: mark a line dirty (CPU write hit)
//   clr_dirty_en/clr_dirty_index: mark a line clean (write-back finished)
// Reset clears valid and dirty; tags are left unreset because an invalid
// line's tag is never looked at.
// -----------------------------------------------------------------------------
module cache_tag_store #(
    parameter int INDEX_W = 2,
    parameter int TAG_W   = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [INDEX_W-1:0] rd_index,
    output logic [TAG_W-1:0]   rd_tag,
    output logic               rd_valid,
    output logic               rd_dirty,
    input  logic               fill_en,
    input  logic [INDEX_W-1:0] fill_index,
    input  logic [TAG_W-1:0]   fill_tag,
    input  logic               set_dirty_en,
    input  logic [INDEX_W-1:0] set_dirty_index,
    input  logic               clr_dirty_en,
    input  logic [INDEX_W-1:0] clr_dirty_index
);

    localparam int LINES = 2 ** INDEX_W;

    logic [LINES-1:0] valid_vec;
    logic [LINES-1:0] dirty_vec;
    logic [TAG_W-1:0] tag_vec [LINES];

    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_line
            logic             valid_q;
            logic             dirty_q;
            logic [TAG_W-1:0] tag_q;
            logic             fill_hit;

            assign fill_hit = fill_en && (fill_index == INDEX_W'(gi));

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    valid_q <= 1'b0;
                    dirty_q <= 1'b0;
                end else if (fill_hit) begin
                    valid_q <= 1'b1;
                    dirty_q <= 1'b0;
                end else if (set_dirty_en && (set_dirty_index == INDEX_W'(gi))) begin
                    dirty_q <= 1'b1;
                end else if (clr_dirty_en && (clr_dirty_index == INDEX_W'(gi))) begin
                    dirty_q <= 1'b0;
                end
            end

            always_ff @(posedge clock) begin
                if (fill_hit) begin
                    tag_q <= fill_tag;
                end
            end

            assign valid_vec[gi] = valid_q;
            assign dirty_vec[gi] = dirty_q;
            assign tag_vec[gi]   = tag_q;
        end
    endgenerate

    assign rd_tag   = tag_vec[rd_index];
    assign rd_valid = valid_vec[rd_index];
    assign rd_dirty = dirty_vec[rd_index];

endmodule

// File: rtl/cache_controller.sv
// -----------------------------------------------------------------------------
// cache_controller
// FSM for a direct-mapped, write-back, write-allocate data cache. It decides
// hit/miss, sequences dirty write-back and block fetch over a req/ready memory
// handshake, and drives the write enables of the external data array.
// Ports:
//   clock, reset_n       : clock, asynchronous active-low reset
//   cpu_valid, cpu_read_write (1=write), cpu_address : CPU request
//   hit_miss             : 1-cycle completion pulse; busy : not IDLE
//   arr_index, arr_offset, arr_cpu_we, arr_fill_we : data-array control
//   mem_req, mem_we (1=write-back), mem_block_addr, mem_ready : memory side
//   hit_count, miss_count: statistics counters
// Optional feature: define CACHE_STATS_EN to build the saturating hit/miss
// counters; without it both count ports are tied to zero.
// -----------------------------------------------------------------------------
module cache_controller
    import cache_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int INDEX_W  = DEF_INDEX_W,
    parameter int OFFSET_W = DEF_OFFSET_W
) (
    input  logic                                    clock,
    input  logic                                    reset_n,
    input  logic                                    cpu_valid,
    input  logic                                    cpu_read_write,
    input  logic [ADDR_W-1:0]                       cpu_address,
    output logic                                    hit_miss,
    output logic                                    busy,
    output logic [INDEX_W-1:0]                      arr_index,
    output logic [OFFSET_W-1:0]                     arr_offset,
    output logic                                    arr_cpu_we,
    output logic                                    arr_fill_we,
    output logic                                    mem_req,
    output logic                                    mem_we,
    output logic [ADDR_W-OFFSET_W-1:0]              mem_block_addr,
    input  logic                                    mem_ready,
    output logic [15:0]                             hit_count,
    output logic [15:0]                             miss_count
);

    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    cache_state_e            state_q;
    logic                    req_we_q;
    logic [TAG_W-1:0]        req_tag_q;
    logic [INDEX_W-1:0]      req_index_q;
    logic [OFFSET_W-1:0]     req_offset_q;
    logic                    mem_req_q;
    logic                    mem_we_q;
    logic [TAG_W+INDEX_W-1:0] mem_block_addr_q;

    logic [TAG_W-1:0] lk_tag;
    logic             lk_valid;
    logic             lk_dirty;
    logic             hit;
    logic             fill;
    logic             wb_done;

    cache_tag_store #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_tag_store (
        .clock           (clock),
        .reset_n         (reset_n),
        .rd_index        (req_index_q),
        .rd_tag          (lk_tag),
        .rd_valid        (lk_valid),
        .rd_dirty        (lk_dirty),
        .fill_en         (fill),
        .fill_index      (req_index_q),
        .fill_tag        (req_tag_q),
        .set_dirty_en    (arr_cpu_we),
        .set_dirty_index (req_index_q),
        .clr_dirty_en    (wb_done),
        .clr_dirty_index (req_index_q)
    );

    assign hit     = (state_q == COMPARE) && lk_valid && (lk_tag == req_tag_q);
    assign fill    = (state_q == ALLOCATE) && mem_req_q && mem_ready;
    assign wb_done = (state_q == WRITE_BACK) && mem_req_q && mem_ready;

    assign hit_miss       = hit;
    assign arr_cpu_we     = hit && req_we_q;
    assign arr_fill_we    = fill;
    assign busy           = (state_q != IDLE);
    assign arr_index      = req_index_q;
    assign arr_offset     = req_offset_q;
    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_block_addr = mem_block_addr_q;

    // mem_req is a flop so request and address stay stable until the ready
    // cycle. After a write-back it drops for one cycle before the fetch is
    // raised, which gives memory a clean boundary between the two requests.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            req_we_q         <= 1'b0;
            req_tag_q        <= '0;
            req_index_q      <= '0;
            req_offset_q     <= '0;
            mem_req_q        <= 1'b0;
            mem_we_q         <= 1'b0;
            mem_block_addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_valid) begin
                        req_we_q     <= cpu_read_write;
                        req_tag_q    <= TAG_W'(addr_tag(32'(cpu_address), INDEX_W, OFFSET_W));
                        req_index_q  <= INDEX_W'(addr_index(32'(cpu_address), INDEX_W, OFFSET_W));
                        req_offset_q <= OFFSET_W'(addr_offset(32'(cpu_address), OFFSET_W));
                        state_q      <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        state_q <= IDLE;
                    end else if (lk_valid && lk_dirty) begin
                        state_q          <= WRITE_BACK;
                        mem_req_q        <= 1'b1;
                        mem_we_q         <= 1'b1;
                        mem_block_addr_q <= {lk_tag, req_index_q};
                    end else begin
                        state_q          <= ALLOCATE;
                        mem_req_q        <= 1'b1;
                        mem_we_q         <= 1'b0;
                        mem_block_addr_q <= {req_tag_q, req_index_q};
                    end
                end
                WRITE_BACK: begin
                    if (mem_ready) begin
                        state_q   <= ALLOCATE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end
                end
                ALLOCATE: begin
                    if (!mem_req_q) begin
                        mem_req_q        <= 1'b1;
                        mem_we_q         <= 1'b0;
                        mem_block_addr_q <= {req_tag_q, req_index_q};
                    end else if (mem_ready) begin
                        mem_req_q <= 1'b0;
                        state_q   <= COMPARE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    logic [15:0] hit_count_q;
    logic [15:0] miss_count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (hit && (hit_count_q != 16'hFFFF)) begin
                hit_count_q <= hit_count_q + 16'd1;
            end
            // Any COMPARE that does not hit leaves for WRITE_BACK or ALLOCATE.
            if ((state_q == COMPARE) && !hit && (miss_count_q != 16'hFFFF)) begin
                miss_count_q <= miss_count_q + 16'd1;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`else
    assign hit_count  = 16'd0;
    assign miss_count = 16'd0;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// -----------------------------------------------------------------------------
// tb_cache_controller
// Directed CPU request sequence against cache_controller with a memory model
// that raises mem_ready in the 4th cycle of each request. The driver pushes
// the hand-computed expectation of every request into a scoreboard queue; a
// monitor follows each transaction and checks it when hit_miss pulses.
// -----------------------------------------------------------------------------
module tb_cache_controller;

    logic        clock;
    logic        reset_n;
    logic        cpu_valid;
    logic        cpu_read_write;
    logic [9:0]  cpu_address;
    logic        hit_miss;
    logic        busy;
    logic [1:0]  arr_index;
    logic [3:0]  arr_offset;
    logic        arr_cpu_we;
    logic        arr_fill_we;
    logic        mem_req;
    logic        mem_we;
    logic [5:0]  mem_block_addr;
    logic        mem_ready;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    logic        model_ready;
    logic        stray_ready;
    int          mem_cnt;

    int vectors;
    int miscompares;
    int txn_no;

    typedef struct {
        logic       we;
        logic [9:0] addr;
        int         lat;
        bit         exp_wb;
        logic [5:0] wb_addr;
        bit         exp_al;
        logic [5:0] al_addr;
    } exp_t;

    exp_t sb_q[$];

    cache_controller dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .cpu_valid      (cpu_valid),
        .cpu_read_write (cpu_read_write),
        .cpu_address    (cpu_address),
        .hit_miss       (hit_miss),
        .busy           (busy),
        .arr_index      (arr_index),
        .arr_offset     (arr_offset),
        .arr_cpu_we     (arr_cpu_we),
        .arr_fill_we    (arr_fill_we),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_block_addr (mem_block_addr),
        .mem_ready      (mem_ready),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    assign mem_ready = model_ready | stray_ready;

    // Memory model: counts cycles of a continuous request, ready in the 4th.
    initial begin
        mem_cnt     = 0;
        model_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (!mem_req) begin
                mem_cnt     = 0;
                model_ready = 1'b0;
            end else begin
                mem_cnt     = mem_cnt + 1;
                model_ready = (mem_cnt == 4);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors = vectors + 1;
        if (act != exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit         in_txn;
    int         lat;
    bit         wb_seen, al_seen, req_open, unstable;
    logic [5:0] wb_addr_seen, al_addr_seen, open_addr;
    logic       open_we;
    int         fills;

    initial begin
        in_txn = 0;
        txn_no = 0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                in_txn = 0;
            end else if (!in_txn) begin
                if (!busy && cpu_valid) begin
                    in_txn   = 1;
                    lat      = 1;
                    wb_seen  = 0;
                    al_seen  = 0;
                    req_open = 0;
                    unstable = 0;
                    fills    = 0;
                end
            end else begin
                lat = lat + 1;
                if (mem_req) begin
                    if (!req_open) begin
                        req_open  = 1;
                        open_addr = mem_block_addr;
                        open_we   = mem_we;
                        if (mem_we) begin
                            wb_seen      = 1;
                            wb_addr_seen = mem_block_addr;
                        end else begin
                            al_seen      = 1;
                            al_addr_seen = mem_block_addr;
                        end
                    end else if (mem_block_addr != open_addr || mem_we != open_we) begin
                        unstable = 1;
                    end
                    if (mem_ready) req_open = 0;
                end else begin
                    req_open = 0;
                end
                if (arr_fill_we) fills = fills + 1;
                if (hit_miss) begin
                    exp_t e;
                    logic [9:0] a;
                    in_txn = 0;
                    txn_no = txn_no + 1;
                    if (sb_q.size() == 0) begin
                        vectors     = vectors + 1;
                        miscompares = miscompares + 1;
                        $display("FAIL unexpected_hit_miss: got a completion, expected none queued");
                    end else begin
                        e = sb_q.pop_front();
                        a = e.addr;
                        $display("txn %0d: %s 0x%03h latency %0d wb=%0d alloc=%0d",
                                 txn_no, e.we ? "write" : "read ", e.addr, lat, wb_seen, al_seen);
                        chk("latency", lat, e.lat);
                        chk("writeback_seen", int'(wb_seen), int'(e.exp_wb));
                        if (e.exp_wb) chk("writeback_addr", int'(wb_addr_seen), int'(e.wb_addr));
                        chk("allocate_seen", int'(al_seen), int'(e.exp_al));
                        if (e.exp_al) chk("allocate_addr", int'(al_addr_seen), int'(e.al_addr));
                        chk("fill_pulses", fills, e.exp_al ? 1 : 0);
                        chk("arr_cpu_we", int'(arr_cpu_we), int'(e.we));
                        chk("arr_index", int'(arr_index), int'(a[5:4]));
                        chk("arr_offset", int'(arr_offset), int'(a[3:0]));
                        chk("mem_stable", int'(unstable), 0);
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic wait_hit();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n = n + 1;
        end while (!hit_miss && n < 100);
        if (!hit_miss) begin
            vectors     = vectors + 1;
            miscompares = miscompares + 1;
            $display("FAIL hit_miss_timeout: got no hit_miss in %0d cycles, expected one", n);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic we, input logic [9:0] addr, input int lat_exp,
                         input bit ewb, input logic [5:0] wba,
                         input bit eal, input logic [5:0] ala);
        exp_t e;
        e.we = we; e.addr = addr; e.lat = lat_exp;
        e.exp_wb = ewb; e.wb_addr = wba; e.exp_al = eal; e.al_addr = ala;
        sb_q.push_back(e);
        cpu_read_write = we;
        cpu_address    = addr;
        cpu_valid      = 1'b1;
        wait_hit();
    endtask

    initial begin
        int n;
        vectors        = 0;
        miscompares    = 0;
        reset_n        = 1'b0;
        cpu_valid      = 1'b0;
        cpu_read_write = 1'b0;
        cpu_address    = '0;
        stray_ready    = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_hit_miss", int'(hit_miss), 0);
        chk("reset_mem_req", int'(mem_req), 0);
        chk("reset_mem_we", int'(mem_we), 0);
        chk("reset_mem_block_addr", int'(mem_block_addr), 0);
        chk("reset_arr_we", int'(arr_cpu_we | arr_fill_we), 0);
        chk("reset_arr_index", int'(arr_index), 0);
        chk("reset_counts", int'(hit_count) + int'(miss_count), 0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // we, addr, latency, writeback?, wb addr, allocate?, alloc addr
        issue(1'b1, 10'h1A8,  7, 0, 6'h00, 1, 6'h1A);
        issue(1'b0, 10'h1A8,  2, 0, 6'h00, 0, 6'h00);
        issue(1'b1, 10'h1A8,  2, 0, 6'h00, 0, 6'h00);
        issue(1'b0, 10'h108,  7, 0, 6'h00, 1, 6'h10);
        issue(1'b0, 10'h128, 12, 1, 6'h1A, 1, 6'h12);
        issue(1'b1, 10'h128,  2, 0, 6'h00, 0, 6'h00);
        issue(1'b0, 10'h12C,  2, 0, 6'h00, 0, 6'h00);
        issue(1'b1, 10'h030,  7, 0, 6'h00, 1, 6'h03);
        issue(1'b0, 10'h034,  2, 0, 6'h00, 0, 6'h00);
        issue(1'b1, 10'h104,  2, 0, 6'h00, 0, 6'h00);
        issue(1'b0, 10'h1A4, 12, 1, 6'h12, 1, 6'h1A);
        issue(1'b0, 10'h1A0,  2, 0, 6'h00, 0, 6'h00);
        cpu_valid = 1'b0;

        @(negedge clock);
`ifdef CACHE_STATS_EN
        chk("hit_count_seq", int'(hit_count), 12);
        chk("miss_count_seq", int'(miss_count), 5);
`else
        chk("hit_count_off", int'(hit_count), 0);
        chk("miss_count_off", int'(miss_count), 0);
`endif

        // A stray mem_ready while idle must not start anything.
        stray_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("stray_ready_busy", int'(busy), 0);
        chk("stray_ready_mem_req", int'(mem_req), 0);
        stray_ready = 1'b0;

        // Dirty line 2 again, then abort its write-back with reset.
        issue(1'b1, 10'h1A8, 2, 0, 6'h00, 0, 6'h00);
        cpu_read_write = 1'b0;
        cpu_address    = 10'h128;
        cpu_valid      = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n = n + 1;
        end while (!(mem_req && mem_we) && n < 20);
        chk("writeback_started", int'(mem_req && mem_we), 1);
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk("abort_mem_req", int'(mem_req), 0);
        chk("abort_mem_we", int'(mem_we), 0);
        chk("abort_busy", int'(busy), 0);
        repeat (2) @(posedge clock);
        #1;
        chk("abort_counts", int'(hit_count) + int'(miss_count), 0);
        begin
            exp_t e;
            e.we = 1'b0; e.addr = 10'h128; e.lat = 7;
            e.exp_wb = 0; e.wb_addr = 6'h00; e.exp_al = 1; e.al_addr = 6'h12;
            sb_q.push_back(e);
        end
        reset_n = 1'b1;
        wait_hit();
        cpu_valid = 1'b0;
        @(negedge clock);
`ifdef CACHE_STATS_EN
        chk("hit_count_after_reset", int'(hit_count), 1);
        chk("miss_count_after_reset", int'(miss_count), 1);
`else
        chk("hit_count_off_end", int'(hit_count), 0);
`endif
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- FSM controller for the direct-mapped, write-back, write-allocate data cache between the CPU request port and main memory.
- Owns the tag, valid and dirty metadata, and decides hit or miss.
- Sequences dirty-block write-back and block allocation over a req/ready memory handshake.
- Drives the write enables of the external data array; data words never pass through this block.

Parameters:
ADDR_W, 10, CPU byte-address width
INDEX_W, 2, index bits (2^INDEX_W lines)
OFFSET_W, 4, byte-offset bits within a block (16-byte blocks, 4 words)
TAG_W, ADDR_W-INDEX_W-OFFSET_W (4), derived, tag width; not overridable

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
cpu_valid  in  1  CPU request present; the current CPU model ties it to 1
cpu_read_write  in  1  1=write, 0=read
cpu_address  in  ADDR_W  byte address, laid out as {tag, index, offset}
hit_miss  out  1  1-cycle pulse: request completed as a hit this cycle; CPU advances on it
busy  out  1  high in every state except IDLE
arr_index  out  INDEX_W  data-array line select
arr_offset  out  OFFSET_W  data-array byte offset
arr_cpu_we  out  1  write CPU word into data array
arr_fill_we  out  1  write the whole block from mem read data into data array
mem_req  out  1  memory request
mem_we  out  1  1=write-back, 0=block fetch
mem_block_addr  out  TAG_W+INDEX_W  block address {tag, index}
mem_ready  in  1  memory completes the current request this cycle
hit_count  out  16  see Optional Feature
miss_count  out  16  see Optional Feature

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State = IDLE; all valid and dirty bits cleared.
  - hit_miss, busy, arr_cpu_we, arr_fill_we, mem_req and mem_we = 0; address outputs = 0.
  - An in-flight memory request is abandoned and mem_req drops at once.
- IDLE:
  - On cpu_valid, latch cpu_read_write and cpu_address into the request registers, then go to COMPARE.
  - mem_ready is ignored in IDLE.
- COMPARE: hit = valid[idx] && tag[idx]==req_tag.
  - Hit, read: hit_miss=1 → IDLE.
  - Hit, write: hit_miss=1, arr_cpu_we=1, dirty[idx]<=1 → IDLE.
  - Miss with valid and dirty line: → WRITE_BACK.
  - Miss otherwise: → ALLOCATE.
- WRITE_BACK:
  - Outputs: mem_req=1, mem_we=1, mem_block_addr={tag[idx], idx}.
  - Outputs hold until mem_ready, then dirty[idx]<=0 → ALLOCATE.
- ALLOCATE:
  - Outputs: mem_req=1, mem_we=0, mem_block_addr={req_tag, idx}.
  - On mem_ready: arr_fill_we=1 for that cycle; tag[idx]<=req_tag, valid<=1, dirty<=0 → COMPARE.
  - The re-compare always hits; a write is then merged via arr_cpu_we and sets dirty.
- Data-array addressing: arr_index and arr_offset come from the latched request registers in all non-IDLE states.
- Latency:
  - Hit: 2 cycles, accept to hit_miss.
  - Clean miss: 3 + memory latency.
  - Dirty miss: 4 + 2×memory latency (equivalently 3 + memory latency + the write-back cycles).
- Single outstanding request only; cpu_address changes while busy are ignored.
- mem_ready with mem_req=0 is ignored.
- mem_req and mem_block_addr are stable from assertion until the mem_ready cycle inclusive.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined:
  - hit_count increments on every hit_miss pulse.
  - miss_count increments on every COMPARE→WRITE_BACK or COMPARE→ALLOCATE transition.
  - Both counters are 16-bit, saturate at 0xFFFF, and reset to 0.
  - The re-compare hit after ALLOCATE counts as a hit.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- cache_pkg holds:
  - State enum: IDLE, COMPARE, WRITE_BACK, ALLOCATE.
  - Default widths.
  - Field-extract functions for tag, index and offset.
- Sub-module cache_tag_store holds the tag, valid and dirty arrays:
  - Ports: asynchronous read by index; synchronous update, fill, set-dirty and clear-dirty.
- The FSM and the optional counters stay in cache_controller.

Test Plan:
- Memory model: mem_ready asserted 4 cycles after mem_req.
- Write 0x1A8 (tag 6, idx 2) from reset → ALLOCATE; fill; re-compare hit with arr_cpu_we; hit_miss after 7 cycles; dirty[2]=1.
- Read 0x1A8, then write 0x1A8 → each hit_miss 2 cycles after accept; no mem_req.
- Read 0x108 (idx 0, clean, empty) → ALLOCATE only, mem_block_addr=0x10, mem_we never 1.
- Read 0x128 (tag 4, idx 2, dirty) → WRITE_BACK with mem_block_addr=0x1A and mem_we=1, then ALLOCATE 0x12; dirty[2]=0 after.
- Drop reset_n mid-WRITE_BACK → mem_req=0 same cycle; state IDLE; next read of 0x128 is a clean miss.
- With CACHE_STATS_EN, run the full 12-request CPU sequence → final miss_count=5, hit_count=12.
